// File: rtl/ball_renderer_pkg.sv
// Constants shared between the ball generator and the renderer: the playfield frame,
// the reset centre, the palette and the bounce-flag encodings.
package ball_renderer_pkg;

    localparam logic [9:0] PF_X_MIN   = 10'd143;
    localparam logic [9:0] PF_X_MAX   = 10'd782;
    localparam logic [9:0] PF_Y_MIN   = 10'd33;
    localparam logic [9:0] PF_Y_MAX   = 10'd513;
    localparam logic [9:0] BALL_X_RST = 10'd463;
    localparam logic [9:0] BALL_Y_RST = 10'd273;

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    localparam logic [11:0] RGB_RED   = 12'hF00;
    localparam logic [11:0] RGB_GREEN = 12'h0F0;

    typedef enum logic [1:0] {
        AXIS_IDLE      = 2'b00,
        AXIS_BOUNCE_LO = 2'b01,
        AXIS_BOUNCE_HI = 2'b10,
        AXIS_FREE      = 2'b11
    } axis_flag_e;

    typedef logic signed [10:0] delta_t;

    // A bounce on either axis restarts the red flash.
    function automatic logic is_bounce(input logic [3:0] f);
        axis_flag_e ax_x;
        axis_flag_e ax_y;
        ax_x = axis_flag_e'(f[3:2]);
        ax_y = axis_flag_e'(f[1:0]);
        return (ax_x == AXIS_BOUNCE_LO) || (ax_x == AXIS_BOUNCE_HI) ||
               (ax_y == AXIS_BOUNCE_LO) || (ax_y == AXIS_BOUNCE_HI);
    endfunction

endpackage

// File: rtl/ball_renderer_disc_test.sv
// Pixel-vs-disc pipeline: register deltas, register squares, then compare; the final
// compare is combinational so the caller's output register forms the third stage.
module disc_test
    import ball_renderer_pkg::*;
#(
    parameter int unsigned     SB_W   = 4,
    parameter logic [SB_W-1:0] SB_RST = '0
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [9:0]      h_i,
    input  logic [9:0]      v_i,
    input  logic [9:0]      cx_i,
    input  logic [9:0]      cy_i,
    input  logic [3:0]      r_i,
    input  logic [SB_W-1:0] sb_i,
    output logic            in_ball_o,
    output logic [SB_W-1:0] sb_o
);

    delta_t          dx_d, dy_d, dx_q, dy_q;
    logic [3:0]      r1_q;
    logic [9:0]      adx, ady;
    logic [19:0]     dx2_d, dy2_d, dx2_q, dy2_q;
    logic [7:0]      s2_d, s2_q;
    logic [20:0]     dist2;
    logic [SB_W-1:0] sb1_q, sb2_q;

    // One extra bit keeps centres near 0 or 1023 from wrapping into the far edge.
    assign dx_d = $signed({1'b0, h_i}) - $signed({1'b0, cx_i});
    assign dy_d = $signed({1'b0, v_i}) - $signed({1'b0, cy_i});

    assign adx   = dx_q[10] ? 10'(-dx_q) : dx_q[9:0];
    assign ady   = dy_q[10] ? 10'(-dy_q) : dy_q[9:0];
    assign dx2_d = {10'b0, adx} * {10'b0, adx};
    assign dy2_d = {10'b0, ady} * {10'b0, ady};
    assign s2_d  = {4'b0, r1_q} * {4'b0, r1_q};

    assign dist2     = {1'b0, dx2_q} + {1'b0, dy2_q};
    assign in_ball_o = dist2 <= {13'b0, s2_q};
    assign sb_o      = sb2_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dx_q  <= '0;
            dy_q  <= '0;
            r1_q  <= '0;
            sb1_q <= SB_RST;
            dx2_q <= '0;
            dy2_q <= '0;
            s2_q  <= '0;
            sb2_q <= SB_RST;
        end else begin
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            r1_q  <= r_i;
            sb1_q <= sb_i;
            dx2_q <= dx2_d;
            dy2_q <= dy2_d;
            s2_q  <= s2_d;
            sb2_q <= sb1_q;
        end
    end

endmodule

// File: rtl/ball_renderer.sv
// Ball renderer: latches the ball state at the end of vertical sync, runs each pixel
// through the disc test and drives 4-bit RGB with syncs aligned to the colour.
module ball_renderer
    import ball_renderer_pkg::*;
#(
    parameter logic [9:0]  X_MIN        = PF_X_MIN,
    parameter logic [9:0]  X_MAX        = PF_X_MAX,
    parameter logic [9:0]  Y_MIN        = PF_Y_MIN,
    parameter logic [9:0]  Y_MAX        = PF_Y_MAX,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter logic [11:0] BG_RGB       = 12'h124
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [9:0] H_Cnt,
    input  logic [9:0] V_Cnt,
    input  logic       Video_On,
    input  logic       HSync_in,
    input  logic       VSync_in,
    input  logic [9:0] Ball_X,
    input  logic [9:0] Ball_Y,
    input  logic [9:0] Ball_S,
    input  logic [3:0] flag,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS
);

    logic       vs_sync_q, vs_prev_q, capture;
    logic [9:0] bx_q, by_q;
    logic [3:0] bs_q, bf_q;
    logic [3:0] flash_d, flash_q;
    logic       border_hit, in_ball;
    logic       von_p, border_p, hs_p, vs_p;
    logic [11:0] rgb_d, rgb_q;
    logic       hs_q, vs_q;
    logic       unused_bits;

    // Only the radius nibble is meaningful; bf is held for observation alongside the counter.
    assign unused_bits = ^{Ball_S[9:4], bf_q};

    // Capture at the end of the sync pulse, a full frame after the generator updated.
    assign capture = vs_sync_q & ~vs_prev_q;

    always_comb begin
        flash_d = flash_q;
        if (is_bounce(flag))
            flash_d = 4'(FLASH_FRAMES);
        else if (flash_q != 4'd0)
            flash_d = flash_q - 4'd1;
    end

    assign border_hit = Video_On && ((H_Cnt == X_MIN) || (H_Cnt == X_MAX) ||
                                     (V_Cnt == Y_MIN) || (V_Cnt == Y_MAX));

    disc_test #(
        .SB_W   (4),
        .SB_RST (4'b0011)
    ) u_disc (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .h_i       (H_Cnt),
        .v_i       (V_Cnt),
        .cx_i      (bx_q),
        .cy_i      (by_q),
        .r_i       (bs_q),
        .sb_i      ({Video_On, border_hit, HSync_in, VSync_in}),
        .in_ball_o (in_ball),
        .sb_o      ({von_p, border_p, hs_p, vs_p})
    );

    always_comb begin
        rgb_d = BG_RGB;
        if (!von_p)
            rgb_d = RGB_BLACK;
        else if (in_ball && (flash_q != 4'd0))
            rgb_d = RGB_RED;
        else if (in_ball)
            rgb_d = RGB_WHITE;
        else if (border_p)
            rgb_d = RGB_GREEN;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_q <= 1'b1;
            vs_prev_q <= 1'b1;
            bx_q      <= BALL_X_RST;
            by_q      <= BALL_Y_RST;
            bs_q      <= 4'd0;
            bf_q      <= 4'b0000;
            flash_q   <= 4'd0;
            rgb_q     <= RGB_BLACK;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            vs_sync_q <= VSync_in;
            vs_prev_q <= vs_sync_q;
            if (capture) begin
                bx_q    <= Ball_X;
                by_q    <= Ball_Y;
                bs_q    <= Ball_S[3:0];
                bf_q    <= flag;
                flash_q <= flash_d;
            end
            rgb_q <= rgb_d;
            hs_q  <= hs_p;
            vs_q  <= vs_p;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;

endmodule
